// File: rtl/vdp_io_port.sv
// vdp_io_port: Z80 data/control port decode, VRAM address/code latch, read-ahead buffer and VRAM handshake.
// Build option VDP_IO_STATUS_EN adds the status flags, status reads and the frame interrupt.
module vdp_io_port #(
  parameter int VRAM_AW = 14,
  parameter int CRAM_AW = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         addr,
  input  logic [7:0]         data_in,
  output logic [7:0]         data_out,
  output logic               data_oe,
  input  logic               IORQ_L,
  input  logic               RD_L,
  input  logic               WR_L,
  output logic               WAIT_L,
  output logic               vram_req,
  output logic               vram_we,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [7:0]         vram_wdata,
  input  logic               vram_ack,
  input  logic [7:0]         vram_rdata,
  output logic               reg_we,
  output logic [3:0]         reg_idx,
  output logic [7:0]         reg_data,
  output logic               cram_we,
  output logic [CRAM_AW-1:0] cram_addr,
  output logic [7:0]         cram_wdata,
  input  logic               frame_set,
  input  logic               ovf_set,
  input  logic               col_set,
  output logic               irq_L
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    VREQ_WR = 2'd1,
    VREQ_RD = 2'd2
  } state_t;

  state_t state, next_state;

  logic               iorq_q, rd_q, wr_q;
  logic [2:0]         addr_q;
  logic [7:0]         data_q;
  logic               sel_now, sel_q, serviced, service;
  logic               is_ctrl, is_rd;
  logic [VRAM_AW-1:0] addr_reg, addr_inc, addr_hi_load;
  logic [1:0]         code;
  logic [7:0]         buffer;
  logic               pending;
  logic [7:0]         status_byte;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^addr[5:1];

  // Only the port-select bits and the data/control bit of the address matter.
  assign sel_now = !IORQ_L && (addr[7:6] == 2'b10) && (!RD_L || !WR_L);
  assign sel_q   = !iorq_q && (addr_q[2:1] == 2'b10) && (!rd_q || !wr_q);
  assign service = (state == IDLE) && sel_q && !serviced;
  assign is_ctrl = addr_q[0];
  assign is_rd   = !rd_q;

  assign addr_inc     = addr_reg + VRAM_AW'(1);
  assign addr_hi_load = VRAM_AW'({data_q[5:0], addr_reg[7:0]});

  // Hold the Z80 off until its access has been serviced and any VRAM cycle it started is done.
  assign WAIT_L  = !(sel_now && ((state != IDLE) || !serviced));
  assign data_oe = sel_now && !RD_L;

  assign vram_req   = (state != IDLE);
  assign vram_we    = (state == VREQ_WR);
  assign vram_addr  = addr_reg;
  assign vram_wdata = buffer;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (service) begin
          if (is_ctrl && !is_rd && pending && (data_q[7:6] == 2'b00)) next_state = VREQ_RD;
          else if (!is_ctrl && is_rd)                                next_state = VREQ_RD;
          else if (!is_ctrl && !is_rd && (code != 2'b11))            next_state = VREQ_WR;
        end
      end
      VREQ_WR, VREQ_RD: begin
        if (vram_ack) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iorq_q     <= 1'b1;
      rd_q       <= 1'b1;
      wr_q       <= 1'b1;
      addr_q     <= '0;
      data_q     <= '0;
      serviced   <= 1'b0;
      data_out   <= '0;
      addr_reg   <= '0;
      code       <= '0;
      buffer     <= '0;
      pending    <= 1'b0;
      reg_we     <= 1'b0;
      reg_idx    <= '0;
      reg_data   <= '0;
      cram_we    <= 1'b0;
      cram_addr  <= '0;
      cram_wdata <= '0;
    end else begin
      iorq_q  <= IORQ_L;
      rd_q    <= RD_L;
      wr_q    <= WR_L;
      addr_q  <= {addr[7:6], addr[0]};
      data_q  <= data_in;
      reg_we  <= 1'b0;
      cram_we <= 1'b0;

      if (iorq_q)       serviced <= 1'b0;
      else if (service) serviced <= 1'b1;

      if (service) begin
        if (is_ctrl) begin
          if (is_rd) begin
            data_out <= status_byte;
            pending  <= 1'b0;
          end else if (!pending) begin
            addr_reg[7:0] <= data_q;
            pending       <= 1'b1;
          end else begin
            code     <= data_q[7:6];
            addr_reg <= addr_hi_load;
            pending  <= 1'b0;
            if (data_q[7:6] == 2'b10) begin
              reg_we   <= 1'b1;
              reg_idx  <= data_q[3:0];
              reg_data <= addr_reg[7:0];
            end
          end
        end else if (is_rd) begin
          data_out <= buffer;
          pending  <= 1'b0;
        end else begin
          pending <= 1'b0;
          buffer  <= data_q;
          // CRAM writes bypass the arbiter, so the address advances right away.
          if (code == 2'b11) begin
            cram_we    <= 1'b1;
            cram_addr  <= addr_reg[CRAM_AW-1:0];
            cram_wdata <= data_q;
            addr_reg   <= addr_inc;
          end
        end
      end else if ((state != IDLE) && vram_ack) begin
        addr_reg <= addr_inc;
        if (state == VREQ_RD) buffer <= vram_rdata;
      end
    end
  end

`ifdef VDP_IO_STATUS_EN
  logic frame, ovf, col, status_rd;

  assign status_rd = service && is_ctrl && is_rd;

  // A set pulse coinciding with the clearing read wins, so no event is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame <= 1'b0;
      ovf   <= 1'b0;
      col   <= 1'b0;
    end else begin
      frame <= frame_set | (frame & !status_rd);
      ovf   <= ovf_set   | (ovf   & !status_rd);
      col   <= col_set   | (col   & !status_rd);
    end
  end

  assign status_byte = {frame, ovf, col, 5'b00000};
  assign irq_L       = ~frame;
`else
  logic unused_status_inputs;

  assign unused_status_inputs = frame_set ^ ovf_set ^ col_set;
  assign status_byte          = 8'h00;
  assign irq_L                = 1'b1;
`endif

endmodule

// File: tb/tb_vdp_io_port.sv
// Bench for vdp_io_port: Z80 port cycles checked against a port-level reference model,
// with a behavioural VRAM arbiter that answers requests after a random delay.
module tb_vdp_io_port;

  localparam int VRAM_AW = 14;
  localparam int CRAM_AW = 5;
`ifdef VDP_IO_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [7:0]         addr = 8'h00;
  logic [7:0]         data_in = 8'h00;
  logic [7:0]         data_out;
  logic               data_oe;
  logic               IORQ_L = 1'b1, RD_L = 1'b1, WR_L = 1'b1;
  logic               WAIT_L;
  logic               vram_req, vram_we;
  logic [VRAM_AW-1:0] vram_addr;
  logic [7:0]         vram_wdata;
  logic               vram_ack = 1'b0;
  logic [7:0]         vram_rdata = 8'h00;
  logic               reg_we;
  logic [3:0]         reg_idx;
  logic [7:0]         reg_data;
  logic               cram_we;
  logic [CRAM_AW-1:0] cram_addr;
  logic [7:0]         cram_wdata;
  logic               frame_set = 1'b0, ovf_set = 1'b0, col_set = 1'b0;
  logic               irq_L;

  always #5 clk = ~clk;

  vdp_io_port #(.VRAM_AW(VRAM_AW), .CRAM_AW(CRAM_AW)) dut (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .data_out(data_out),
    .data_oe(data_oe), .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L), .WAIT_L(WAIT_L),
    .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
    .vram_ack(vram_ack), .vram_rdata(vram_rdata), .reg_we(reg_we), .reg_idx(reg_idx),
    .reg_data(reg_data), .cram_we(cram_we), .cram_addr(cram_addr), .cram_wdata(cram_wdata),
    .frame_set(frame_set), .ovf_set(ovf_set), .col_set(col_set), .irq_L(irq_L)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // vmem is what the arbiter serves; exp_mem is what the model believes VRAM holds.
  logic [7:0]  vmem    [16384];
  logic [7:0]  exp_mem [16384];
  logic [21:0] act_vw[$],   exp_vw[$];
  logic [11:0] act_reg[$],  exp_reg[$];
  logic [12:0] act_cram[$], exp_cram[$];
  int          req_cycles = 0;
  bit          arb_en = 1'b1;
  int          ack_dly = 0;
  bit          req_open = 1'b0;
  logic [22:0] req_fields;

  logic [13:0] m_addr;
  logic [1:0]  m_code;
  bit          m_pending;
  logic [7:0]  m_buf;
  bit          m_frame, m_ovf, m_col;

  // Arbiter model: acks after 0-3 cycles and checks the request stayed put while waiting.
  always @(negedge clk) begin
    if (vram_req === 1'b1) req_cycles++;
    if (reset === 1'b1) begin
      vram_ack = 1'b0;
      req_open = 1'b0;
    end else if (vram_ack) begin
      vram_ack = 1'b0;
    end else if (arb_en && vram_req === 1'b1) begin
      if (!req_open) begin
        req_open   = 1'b1;
        req_fields = {vram_addr, vram_we, vram_wdata};
        ack_dly    = $urandom_range(0, 3);
      end
      if (ack_dly == 0) begin
        n_checks++;
        if ({vram_addr, vram_we, vram_wdata} !== req_fields) begin
          n_fail++;
          $display("[TB] FAIL req_hold: fields %h, required %h", {vram_addr, vram_we, vram_wdata}, req_fields);
        end
        vram_ack = 1'b1;
        req_open = 1'b0;
        if (vram_we) begin
          vmem[vram_addr] = vram_wdata;
          act_vw.push_back({vram_addr, vram_wdata});
        end else begin
          vram_rdata = vmem[vram_addr];
        end
      end else begin
        ack_dly--;
      end
    end
  end

  always @(negedge clk) begin
    if (reg_we === 1'b1)  act_reg.push_back({reg_idx, reg_data});
    if (cram_we === 1'b1) act_cram.push_back({cram_addr, cram_wdata});
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_reset();
    m_addr = '0; m_code = '0; m_pending = 0; m_buf = '0;
    m_frame = 0; m_ovf = 0; m_col = 0;
  endtask

  task automatic clear_logs();
    act_vw.delete(); exp_vw.delete(); act_reg.delete(); exp_reg.delete();
    act_cram.delete(); exp_cram.delete();
  endtask

  // One Z80 I/O cycle; optionally pulses frame_set on the clock edge the access is serviced.
  task automatic io_cycle(input logic [7:0] a, input bit rd, input logic [7:0] wd,
                          input bit pulse_frame, output logic [7:0] rdat, output logic oe);
    int cnt = 0;
    @(negedge clk);
    addr = a; data_in = wd; IORQ_L = 1'b0; RD_L = !rd; WR_L = rd;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) frame_set = pulse_frame;
      if (cnt == 2) frame_set = 1'b0;
    end while (WAIT_L !== 1'b1 && cnt < 100);
    frame_set = 1'b0;
    rdat = data_out;
    oe   = data_oe;
    if (WAIT_L !== 1'b1) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL io_timeout: WAIT_L %b after %0d cycles, required 1", WAIT_L, cnt);
    end
    IORQ_L = 1'b1; RD_L = 1'b1; WR_L = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic op_ctrl_wr(input logic [7:0] d);
    logic [7:0] r; logic oe;
    io_cycle(8'hBF, 1'b0, d, 1'b0, r, oe);
    if (!m_pending) begin
      m_addr[7:0] = d;
      m_pending   = 1;
    end else begin
      m_code       = d[7:6];
      m_addr[13:8] = d[5:0];
      m_pending    = 0;
      if (m_code == 2'd0) begin
        m_buf  = exp_mem[m_addr];
        m_addr = m_addr + 14'd1;
      end
      if (m_code == 2'd2) exp_reg.push_back({d[3:0], m_addr[7:0]});
    end
  endtask

  task automatic op_data_wr(input logic [7:0] d);
    logic [7:0] r; logic oe;
    io_cycle(8'hBE, 1'b0, d, 1'b0, r, oe);
    m_pending = 0;
    m_buf     = d;
    if (m_code == 2'd3) begin
      exp_cram.push_back({m_addr[4:0], d});
    end else begin
      exp_mem[m_addr] = d;
      exp_vw.push_back({m_addr, d});
    end
    m_addr = m_addr + 14'd1;
  endtask

  task automatic op_data_rd(output logic [7:0] exp, output logic [7:0] act, output logic oe);
    io_cycle(8'hBE, 1'b1, 8'h00, 1'b0, act, oe);
    exp       = m_buf;
    m_pending = 0;
    m_buf     = exp_mem[m_addr];
    m_addr    = m_addr + 14'd1;
  endtask

  task automatic op_ctrl_rd(input bit pulse, output logic [7:0] exp, output logic [7:0] act, output logic oe);
    io_cycle(8'hBF, 1'b1, 8'h00, pulse, act, oe);
    exp       = STATUS_EN ? {m_frame, m_ovf, m_col, 5'b00000} : 8'h00;
    m_pending = 0;
    m_frame   = STATUS_EN && pulse;
    m_ovf     = 0;
    m_col     = 0;
  endtask

  task automatic op_pulse(input bit f, input bit o, input bit c);
    @(negedge clk);
    frame_set = f; ovf_set = o; col_set = c;
    @(negedge clk);
    frame_set = 1'b0; ovf_set = 1'b0; col_set = 1'b0;
    if (STATUS_EN) begin
      m_frame |= f; m_ovf |= o; m_col |= c;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks++; if (data_oe !== 1'b0)  begin n_fail++; $display("[TB] FAIL rst_data_oe: %b, required 0", data_oe); end
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_data_out: %h, required 00", data_out); end
    n_checks++; if (WAIT_L !== 1'b1)   begin n_fail++; $display("[TB] FAIL rst_wait: %b, required 1", WAIT_L); end
    n_checks++; if (vram_req !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_vram_req: %b, required 0", vram_req); end
    n_checks++; if (vram_we !== 1'b0)  begin n_fail++; $display("[TB] FAIL rst_vram_we: %b, required 0", vram_we); end
    n_checks++; if (reg_we !== 1'b0)   begin n_fail++; $display("[TB] FAIL rst_reg_we: %b, required 0", reg_we); end
    n_checks++; if (cram_we !== 1'b0)  begin n_fail++; $display("[TB] FAIL rst_cram_we: %b, required 0", cram_we); end
    n_checks++; if (irq_L !== 1'b1)    begin n_fail++; $display("[TB] FAIL rst_irq: %b, required 1", irq_L); end
  endtask

  task automatic test_vram_write();
    logic [21:0] got;
    clear_logs();
    op_ctrl_wr(8'h00); op_ctrl_wr(8'h40); op_data_wr(8'hDD);
    got = (act_vw.size() == 1) ? act_vw[0] : '1;
    n_checks++; if (got !== {14'h0000, 8'hDD}) begin n_fail++; $display("[TB] FAIL vram_write: entry %h (count %0d), required %h", got, act_vw.size(), {14'h0000, 8'hDD}); end
    op_data_wr(8'hEE);
    got = (act_vw.size() == 2) ? act_vw[1] : '1;
    n_checks++; if (got !== {14'h0001, 8'hEE}) begin n_fail++; $display("[TB] FAIL vram_write_incr: entry %h, required %h", got, {14'h0001, 8'hEE}); end
  endtask

  task automatic test_reg_write();
    logic [11:0] got;
    int rc;
    clear_logs();
    rc = req_cycles;
    op_ctrl_wr(8'hBB); op_ctrl_wr(8'h81);
    got = (act_reg.size() == 1) ? act_reg[0] : '1;
    n_checks++; if (got !== {4'h1, 8'hBB}) begin n_fail++; $display("[TB] FAIL reg_write: entry %h (count %0d), required %h", got, act_reg.size(), {4'h1, 8'hBB}); end
    n_checks++; if (req_cycles !== rc) begin n_fail++; $display("[TB] FAIL reg_no_vram: %0d request cycles, required 0", req_cycles - rc); end
  endtask

  task automatic test_prefetch_read();
    logic [7:0] e, r; logic oe; logic [21:0] got;
    clear_logs();
    vmem[14'h0010] = 8'h5A; exp_mem[14'h0010] = 8'h5A;
    vmem[14'h0011] = 8'h33; exp_mem[14'h0011] = 8'h33;
    op_ctrl_wr(8'h10); op_ctrl_wr(8'h00);
    op_data_rd(e, r, oe);
    n_checks++; if (r !== 8'h5A || r !== e) begin n_fail++; $display("[TB] FAIL prefetch_rd1: %h, required 5A", r); end
    n_checks++; if (oe !== 1'b1) begin n_fail++; $display("[TB] FAIL read_oe: %b, required 1", oe); end
    op_data_rd(e, r, oe);
    n_checks++; if (r !== 8'h33 || r !== e) begin n_fail++; $display("[TB] FAIL prefetch_rd2: %h, required 33", r); end
    op_data_wr(8'h77);
    got = (act_vw.size() == 1) ? act_vw[0] : '1;
    n_checks++; if (got !== {14'h0013, 8'h77}) begin n_fail++; $display("[TB] FAIL prefetch_addr: entry %h, required %h", got, {14'h0013, 8'h77}); end
  endtask

  task automatic test_pending_clear();
    logic [7:0] e, r; logic oe; logic [21:0] got;
    clear_logs();
    op_ctrl_wr(8'hBB);
    op_data_rd(e, r, oe);
    n_checks++; if (r !== e) begin n_fail++; $display("[TB] FAIL pend_read: %h, required %h", r, e); end
    op_ctrl_wr(8'h22); op_ctrl_wr(8'h45); op_data_wr(8'h66);
    got = (act_vw.size() == 1) ? act_vw[0] : '1;
    n_checks++; if (got !== {14'h0522, 8'h66}) begin n_fail++; $display("[TB] FAIL pend_clear: entry %h, required %h", got, {14'h0522, 8'h66}); end
  endtask

  task automatic test_wrap_and_cram();
    logic [21:0] got; logic [12:0] cg;
    clear_logs();
    op_ctrl_wr(8'hFF); op_ctrl_wr(8'h7F);
    op_data_wr(8'h11); op_data_wr(8'h22);
    got = (act_vw.size() == 2) ? act_vw[0] : '1;
    n_checks++; if (got !== {14'h3FFF, 8'h11}) begin n_fail++; $display("[TB] FAIL wrap_top: entry %h, required %h", got, {14'h3FFF, 8'h11}); end
    got = (act_vw.size() == 2) ? act_vw[1] : '1;
    n_checks++; if (got !== {14'h0000, 8'h22}) begin n_fail++; $display("[TB] FAIL wrap_zero: entry %h, required %h", got, {14'h0000, 8'h22}); end
    op_ctrl_wr(8'h05); op_ctrl_wr(8'hC0);
    op_data_wr(8'h3F); op_data_wr(8'h40);
    cg = (act_cram.size() == 2) ? act_cram[0] : '1;
    n_checks++; if (cg !== {5'd5, 8'h3F}) begin n_fail++; $display("[TB] FAIL cram_write: entry %h, required %h", cg, {5'd5, 8'h3F}); end
    cg = (act_cram.size() == 2) ? act_cram[1] : '1;
    n_checks++; if (cg !== {5'd6, 8'h40}) begin n_fail++; $display("[TB] FAIL cram_incr: entry %h, required %h", cg, {5'd6, 8'h40}); end
    n_checks++; if (act_vw.size() !== 2) begin n_fail++; $display("[TB] FAIL cram_no_vram: %0d VRAM writes, required 2", act_vw.size()); end
  endtask

  task automatic test_status();
    logic [7:0] e, r; logic oe;
    op_ctrl_rd(1'b0, e, r, oe);
    op_pulse(1'b1, 1'b0, 1'b0);
    n_checks++; if (irq_L !== (STATUS_EN ? 1'b0 : 1'b1)) begin n_fail++; $display("[TB] FAIL irq_assert: %b, required %b", irq_L, !STATUS_EN); end
    op_ctrl_rd(1'b0, e, r, oe);
    n_checks++; if (r !== e) begin n_fail++; $display("[TB] FAIL status_frame: %h, required %h", r, e); end
    n_checks++; if (irq_L !== 1'b1) begin n_fail++; $display("[TB] FAIL irq_clear: %b, required 1", irq_L); end
    op_pulse(1'b1, 1'b0, 1'b0);
    op_ctrl_rd(1'b1, e, r, oe);
    n_checks++; if (r !== e) begin n_fail++; $display("[TB] FAIL status_race_rd: %h, required %h", r, e); end
    n_checks++; if (irq_L !== !m_frame) begin n_fail++; $display("[TB] FAIL status_race_keep: irq %b, required %b", irq_L, !m_frame); end
    op_ctrl_rd(1'b0, e, r, oe);
    n_checks++; if (r !== e) begin n_fail++; $display("[TB] FAIL status_after_race: %h, required %h", r, e); end
    op_pulse(1'b0, 1'b1, 1'b1);
    op_ctrl_rd(1'b0, e, r, oe);
    n_checks++; if (r !== e) begin n_fail++; $display("[TB] FAIL status_ovf_col: %h, required %h", r, e); end
  endtask

  task automatic test_random();
    logic [7:0] e, r; logic oe;
    clear_logs();
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: op_ctrl_wr(8'($urandom));
        3, 4:    op_data_wr(8'($urandom));
        5, 6: begin
          op_data_rd(e, r, oe);
          n_checks++; if (r !== e) begin n_fail++; $display("[TB] FAIL rand_data_rd[%0d]: %h, required %h", i, r, e); end
        end
        7: begin
          op_ctrl_rd($urandom_range(0, 3) == 0, e, r, oe);
          n_checks++; if (r !== e) begin n_fail++; $display("[TB] FAIL rand_status_rd[%0d]: %h, required %h", i, r, e); end
        end
        8: op_pulse($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        default: begin
          n_checks++; if (irq_L !== (STATUS_EN ? !m_frame : 1'b1)) begin n_fail++; $display("[TB] FAIL rand_irq[%0d]: %b, required %b", i, irq_L, STATUS_EN ? !m_frame : 1'b1); end
        end
      endcase
    end
    n_checks++; if (act_vw !== exp_vw) begin n_fail++; $display("[TB] FAIL rand_vram_log: %0d writes, required %0d", act_vw.size(), exp_vw.size()); end
    n_checks++; if (act_reg !== exp_reg) begin n_fail++; $display("[TB] FAIL rand_reg_log: %0d writes, required %0d", act_reg.size(), exp_reg.size()); end
    n_checks++; if (act_cram !== exp_cram) begin n_fail++; $display("[TB] FAIL rand_cram_log: %0d writes, required %0d", act_cram.size(), exp_cram.size()); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e, r; logic oe;
    int cnt = 0;
    arb_en = 1'b0;
    @(negedge clk);
    addr = 8'hBE; IORQ_L = 1'b0; RD_L = 1'b0;
    while (vram_req !== 1'b1 && cnt < 10) begin @(negedge clk); cnt++; end
    n_checks++; if (vram_req !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_req_start: %b, required 1", vram_req); end
    reset = 1'b1; IORQ_L = 1'b1; RD_L = 1'b1;
    @(negedge clk);
    n_checks++; if (vram_req !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_abandon: %b, required 0", vram_req); end
    reset = 1'b0;
    model_reset();
    arb_en = 1'b1;
    repeat (2) @(negedge clk);
    op_data_rd(e, r, oe);
    n_checks++; if (r !== 8'h00 || r !== e) begin n_fail++; $display("[TB] FAIL mid_buffer_reset: %h, required 00", r); end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      vmem[i]    = 8'($urandom);
      exp_mem[i] = vmem[i];
    end
    model_reset();
    test_reset();
    test_vram_write();
    test_reg_write();
    test_prefetch_read();
    test_pending_clear();
    test_wrap_and_cram();
    test_status();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
